alu_issue_unit: RTL and testbench

- Command-driven issue/writeback stage wrapped around the combinational 16-bit ALU.
- Accepts one operation per valid/ready handshake and reads operands from a small internal register file (or an immediate).
- Drives the ALU's A/B/FuncCode inputs, captures C and OverflowFlag, and writes the result back to the register file.
- Reports each writeback and keeps a sticky overflow status; sits between the lab testbench/controller and the ALU.

---
 rtl/alu_issue_unit_if.sv | 45 ++++
 rtl/alu_issue_unit.sv | 99 +++++++++
 tb/tb_alu_issue_unit.sv | 298 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/alu_issue_unit_if.sv
// Command, ALU-side and writeback signals of alu_issue_unit, grouped into one bundle.
// The master side is the controller/bench that also hosts the combinational ALU.
interface alu_issue_unit_if #(
  parameter int data_width = 16,
  parameter int addr_width = 2
);
  logic                  cmd_valid;
  logic                  cmd_ready;
  logic [3:0]            cmd_func;
  logic [addr_width-1:0] cmd_rd;
  logic [addr_width-1:0] cmd_rs;
  logic [addr_width-1:0] cmd_rt;
  logic                  cmd_imm_sel;
  logic [data_width-1:0] cmd_imm;

  logic [data_width-1:0] alu_A;
  logic [data_width-1:0] alu_B;
  logic [3:0]            alu_FuncCode;
  logic [data_width-1:0] alu_C;
  logic                  alu_OverflowFlag;

  logic                  wb_valid;
  logic [addr_width-1:0] wb_rd;
  logic [data_width-1:0] wb_data;
  logic                  wb_overflow;
  logic                  sticky_overflow;
  logic                  clear_sticky;

  logic [addr_width-1:0] dbg_addr;
  logic [data_width-1:0] dbg_data;

  modport master (
    output cmd_valid, cmd_func, cmd_rd, cmd_rs, cmd_rt, cmd_imm_sel, cmd_imm,
    output alu_C, alu_OverflowFlag, clear_sticky, dbg_addr,
    input  cmd_ready, alu_A, alu_B, alu_FuncCode,
    input  wb_valid, wb_rd, wb_data, wb_overflow, sticky_overflow, dbg_data
  );

  modport slave (
    input  cmd_valid, cmd_func, cmd_rd, cmd_rs, cmd_rt, cmd_imm_sel, cmd_imm,
    input  alu_C, alu_OverflowFlag, clear_sticky, dbg_addr,
    output cmd_ready, alu_A, alu_B, alu_FuncCode,
    output wb_valid, wb_rd, wb_data, wb_overflow, sticky_overflow, dbg_data
  );
endinterface

// File: rtl/alu_issue_unit.sv
// Issue/writeback stage around the combinational ALU: reads operands from a small
// register file, lets the ALU settle for one cycle, then writes the result back.
module alu_issue_unit #(
  parameter int data_width = 16,
  parameter int reg_count  = 4,
  parameter int addr_width = 2
) (
  input  logic              clk,
  input  logic              reset,
  alu_issue_unit_if.slave   bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    WB   = 2'd2
  } stateT;

  stateT                 state;
  stateT                 nextState;
  logic [data_width-1:0] regFile [reg_count];
  logic [addr_width-1:0] rdLatch;
  logic                  accept;
  logic                  isArith;
  logic                  ovMasked;

  assign accept   = (state == IDLE) && bus.cmd_valid;
  // Only ADD/SUB produce a meaningful flag; other codes may leave a stale one.
  assign isArith  = (bus.alu_FuncCode[3:1] == 3'b000);
  assign ovMasked = isArith && bus.alu_OverflowFlag;
  assign bus.dbg_data = regFile[bus.dbg_addr];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= nextState;
    end
  end

  always_comb begin
    nextState     = state;
    bus.cmd_ready = 1'b0;
    case (state)
      IDLE: begin
        bus.cmd_ready = 1'b1;
        if (bus.cmd_valid) begin
          nextState = EXEC;
        end
      end
      EXEC:    nextState = WB;
      WB:      nextState = IDLE;
      default: nextState = IDLE;
    endcase
  end

  // Operand capture at accept, result writeback at the end of EXEC.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < reg_count; i++) begin
        regFile[i] <= '0;
      end
      rdLatch          <= '0;
      bus.alu_A        <= '0;
      bus.alu_B        <= '0;
      bus.alu_FuncCode <= '0;
      bus.wb_valid     <= 1'b0;
      bus.wb_rd        <= '0;
      bus.wb_data      <= '0;
      bus.wb_overflow  <= 1'b0;
    end else begin
      if (accept) begin
        bus.alu_A        <= regFile[bus.cmd_rs];
        bus.alu_B        <= bus.cmd_imm_sel ? bus.cmd_imm : regFile[bus.cmd_rt];
        bus.alu_FuncCode <= bus.cmd_func;
        rdLatch          <= bus.cmd_rd;
      end
      bus.wb_valid <= (state == EXEC);
      if (state == EXEC) begin
        regFile[rdLatch] <= bus.alu_C;
        bus.wb_rd        <= rdLatch;
        bus.wb_data      <= bus.alu_C;
        bus.wb_overflow  <= ovMasked;
      end
    end
  end

  // A new overflow takes priority over a clear arriving on the same edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bus.sticky_overflow <= 1'b0;
    end else if ((state == EXEC) && ovMasked) begin
      bus.sticky_overflow <= 1'b1;
    end else if (bus.clear_sticky) begin
      bus.sticky_overflow <= 1'b0;
    end
  end

endmodule

// File: tb/tb_alu_issue_unit.sv
// Directed bench for alu_issue_unit with a behavioural ALU and a writeback scoreboard.
module tb_alu_issue_unit;
  localparam int DW = 16;
  localparam int AW = 2;
  localparam int RC = 4;

  localparam logic [3:0] F_ADD = 4'b0000;
  localparam logic [3:0] F_SUB = 4'b0001;
  localparam logic [3:0] F_NOT = 4'b0011;
  localparam logic [3:0] F_AND = 4'b0100;
  localparam logic [3:0] F_XOR = 4'b1000;
  localparam logic [3:0] F_LLS = 4'b1010;
  localparam logic [3:0] F_TCP = 4'b1110;

  typedef struct packed {
    logic [AW-1:0] rd;
    logic [DW-1:0] data;
    logic          ov;
  } wbExpT;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  alu_issue_unit_if #(.data_width(DW), .addr_width(AW)) bus ();

  alu_issue_unit #(.data_width(DW), .reg_count(RC), .addr_width(AW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  wbExpT         sbQ[$];
  int            acceptLog[$];
  logic [DW-1:0] shadow [RC];
  int            compared   = 0;
  int            mismatched = 0;
  int            wbCount    = 0;
  int            cycleCnt   = 0;

  // Behavioural ALU; non-arithmetic codes deliberately leave the flag high (stale).
  function automatic logic [DW:0] refAlu(input logic [3:0] f, input logic [DW-1:0] a,
                                         input logic [DW-1:0] b);
    logic [DW-1:0] r;
    logic          ov;
    r  = '0;
    ov = 1'b1;
    case (f)
      4'd0: begin r = a + b; ov = (a[DW-1] == b[DW-1]) && (r[DW-1] != a[DW-1]); end
      4'd1: begin r = a - b; ov = (a[DW-1] != b[DW-1]) && (r[DW-1] != a[DW-1]); end
      4'd2: r = a;
      4'd3: r = ~a;
      4'd4: r = a & b;
      4'd5: r = a | b;
      4'd6: r = ~(a & b);
      4'd7: r = ~(a | b);
      4'd8: r = a ^ b;
      4'd9: r = ~(a ^ b);
      4'd10: r = a << 1;
      4'd11: r = a >> 1;
      4'd12: r = a <<< 1;
      4'd13: r = $signed(a) >>> 1;
      4'd14: r = -a;
      default: r = '0;
    endcase
    return {ov, r};
  endfunction

  always_comb begin
    {bus.alu_OverflowFlag, bus.alu_C} = refAlu(bus.alu_FuncCode, bus.alu_A, bus.alu_B);
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Drives the command fields and records what the writeback must look like.
  task automatic applyStimulus(input logic [3:0] f, input logic [AW-1:0] rd,
                               input logic [AW-1:0] rs, input logic [AW-1:0] rt,
                               input logic immSel, input logic [DW-1:0] imm);
    logic [DW-1:0] b;
    logic [DW:0]   res;
    wbExpT         e;
    bus.cmd_func    = f;
    bus.cmd_rd      = rd;
    bus.cmd_rs      = rs;
    bus.cmd_rt      = rt;
    bus.cmd_imm_sel = immSel;
    bus.cmd_imm     = imm;
    b    = immSel ? imm : shadow[rt];
    res  = refAlu(f, shadow[rs], b);
    e.rd   = rd;
    e.data = res[DW-1:0];
    e.ov   = (f[3:1] == 3'b000) ? res[DW] : 1'b0;
    sbQ.push_back(e);
    shadow[rd] = res[DW-1:0];
  endtask

  // Waits for IDLE, presents one command and returns just after the accept edge.
  task automatic issueOne(input logic [3:0] f, input logic [AW-1:0] rd,
                          input logic [AW-1:0] rs, input logic [AW-1:0] rt,
                          input logic immSel, input logic [DW-1:0] imm);
    int n = 0;
    @(negedge clk);
    while (bus.cmd_ready !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (n >= 20) checkOutput("readyTimeout", 32'd0, 32'd1);
    applyStimulus(f, rd, rs, rt, immSel, imm);
    bus.cmd_valid = 1'b1;
    @(posedge clk);
    #1 bus.cmd_valid = 1'b0;
  endtask

  task automatic runWb(input string tag);
    @(negedge clk);
    checkOutput({tag, ".execNoWb"}, bus.wb_valid, 1'b0);
    @(negedge clk);
    checkOutput({tag, ".wbPulse"}, bus.wb_valid, 1'b1);
    @(negedge clk);
    checkOutput({tag, ".wbDone"}, bus.wb_valid, 1'b0);
    checkOutput({tag, ".readyBack"}, bus.cmd_ready, 1'b1);
  endtask

  always @(negedge clk) cycleCnt++;

  always @(posedge clk) begin
    if (reset === 1'b0 && bus.cmd_valid === 1'b1 && bus.cmd_ready === 1'b1)
      acceptLog.push_back(cycleCnt);
  end

  // Scoreboard: every writeback pulse must match the oldest outstanding command.
  always @(negedge clk) begin
    wbExpT e;
    if (bus.wb_valid === 1'b1) begin
      wbCount++;
      if (sbQ.size() == 0) begin
        checkOutput("wbUnexpected", 32'd1, 32'd0);
      end else begin
        e = sbQ.pop_front();
        checkOutput("sb.wb_rd", bus.wb_rd, e.rd);
        checkOutput("sb.wb_data", bus.wb_data, e.data);
        checkOutput("sb.wb_overflow", bus.wb_overflow, e.ov);
      end
    end
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [3:0]    cFunc [3];
    logic [AW-1:0] cRd [3];
    logic [AW-1:0] cRs [3];
    logic [AW-1:0] cRt [3];
    int            wbStart;

    for (int i = 0; i < RC; i++) shadow[i] = '0;
    reset            = 1'b1;
    bus.cmd_valid    = 1'b0;
    bus.cmd_func     = '0;
    bus.cmd_rd       = '0;
    bus.cmd_rs       = '0;
    bus.cmd_rt       = '0;
    bus.cmd_imm_sel  = 1'b0;
    bus.cmd_imm      = '0;
    bus.clear_sticky = 1'b0;
    bus.dbg_addr     = '0;
    repeat (2) @(negedge clk);
    reset = 1'b0;

    for (int i = 0; i < RC; i++) begin
      bus.dbg_addr = AW'(i);
      #1 checkOutput($sformatf("reset.reg%0d", i), bus.dbg_data, 16'h0000);
    end
    checkOutput("reset.cmd_ready", bus.cmd_ready, 1'b1);
    checkOutput("reset.wb_valid", bus.wb_valid, 1'b0);
    checkOutput("reset.sticky", bus.sticky_overflow, 1'b0);

    // ADD r1 = r0 + 0x7FFF, with operand and read-before-write checks in EXEC
    issueOne(F_ADD, 2'd1, 2'd0, 2'd0, 1'b1, 16'h7FFF);
    bus.dbg_addr = 2'd1;
    @(negedge clk);
    checkOutput("add1.alu_A", bus.alu_A, 16'h0000);
    checkOutput("add1.alu_B", bus.alu_B, 16'h7FFF);
    checkOutput("add1.func", bus.alu_FuncCode, F_ADD);
    checkOutput("add1.readyLowExec", bus.cmd_ready, 1'b0);
    checkOutput("add1.dbgOld", bus.dbg_data, 16'h0000);
    checkOutput("add1.execNoWb", bus.wb_valid, 1'b0);
    @(negedge clk);
    checkOutput("add1.wbPulse", bus.wb_valid, 1'b1);
    checkOutput("add1.readyLowWb", bus.cmd_ready, 1'b0);
    checkOutput("add1.dbgNew", bus.dbg_data, 16'h7FFF);
    @(negedge clk);
    checkOutput("add1.wbDone", bus.wb_valid, 1'b0);

    // ADD r2 = r1 + 1 overflows into 0x8000
    issueOne(F_ADD, 2'd2, 2'd1, 2'd0, 1'b1, 16'h0001);
    runWb("add2");
    checkOutput("add2.sticky", bus.sticky_overflow, 1'b1);
    checkOutput("add2.wb_overflow", bus.wb_overflow, 1'b1);

    // XOR r3 = r2 ^ r1: the model's stale flag must be masked
    issueOne(F_XOR, 2'd3, 2'd2, 2'd1, 1'b0, 16'h0000);
    runWb("xor");
    checkOutput("xor.wb_data", bus.wb_data, 16'hFFFF);
    checkOutput("xor.wb_overflow", bus.wb_overflow, 1'b0);
    checkOutput("xor.stickyHeld", bus.sticky_overflow, 1'b1);

    // Overflowing SUB with clear_sticky on the same (writeback) edge: set wins
    bus.clear_sticky = 1'b1;
    @(negedge clk);
    bus.clear_sticky = 1'b0;
    checkOutput("clr.preSub", bus.sticky_overflow, 1'b0);
    issueOne(F_SUB, 2'd0, 2'd2, 2'd0, 1'b1, 16'h0001);
    bus.clear_sticky = 1'b1;
    @(negedge clk);
    checkOutput("sub.execNoWb", bus.wb_valid, 1'b0);
    @(posedge clk);
    #1 bus.clear_sticky = 1'b0;
    @(negedge clk);
    checkOutput("sub.wbPulse", bus.wb_valid, 1'b1);
    checkOutput("sub.setWins", bus.sticky_overflow, 1'b1);
    checkOutput("sub.wb_data", bus.wb_data, 16'h7FFF);
    @(negedge clk);
    bus.clear_sticky = 1'b1;
    @(negedge clk);
    bus.clear_sticky = 1'b0;
    checkOutput("clr.alone", bus.sticky_overflow, 1'b0);

    // Three back-to-back commands with cmd_valid held high throughout
    cFunc[0] = F_AND; cRd[0] = 2'd1; cRs[0] = 2'd1; cRt[0] = 2'd3;
    cFunc[1] = F_NOT; cRd[1] = 2'd2; cRs[1] = 2'd1; cRt[1] = 2'd0;
    cFunc[2] = F_LLS; cRd[2] = 2'd3; cRs[2] = 2'd3; cRt[2] = 2'd0;
    acceptLog.delete();
    wbStart = wbCount;
    @(negedge clk);
    applyStimulus(cFunc[0], cRd[0], cRs[0], cRt[0], 1'b0, 16'h0000);
    bus.cmd_valid = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      checkOutput($sformatf("burst%0d.readyExec", k), bus.cmd_ready, 1'b0);
      @(negedge clk);
      checkOutput($sformatf("burst%0d.readyWb", k), bus.cmd_ready, 1'b0);
      checkOutput($sformatf("burst%0d.wbPulse", k), bus.wb_valid, 1'b1);
      @(negedge clk);
      checkOutput($sformatf("burst%0d.readyIdle", k), bus.cmd_ready, 1'b1);
      if (k < 2) applyStimulus(cFunc[k+1], cRd[k+1], cRs[k+1], cRt[k+1], 1'b0, 16'h0000);
      else bus.cmd_valid = 1'b0;
    end
    @(negedge clk);
    checkOutput("burst.accepts", acceptLog.size(), 3);
    if (acceptLog.size() == 3) begin
      checkOutput("burst.gap01", acceptLog[1] - acceptLog[0], 3);
      checkOutput("burst.gap12", acceptLog[2] - acceptLog[1], 3);
    end
    checkOutput("burst.wbCount", wbCount - wbStart, 3);
    bus.dbg_addr = 2'd3;
    #1 checkOutput("burst.reg3", bus.dbg_data, 16'hFFFE);

    // Reset during EXEC of TCP aborts the command without a writeback
    issueOne(F_TCP, 2'd1, 2'd3, 2'd0, 1'b0, 16'h0000);
    wbStart = wbCount;
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    sbQ.delete();
    for (int i = 0; i < RC; i++) shadow[i] = '0;
    repeat (3) @(negedge clk);
    checkOutput("rst.noWb", wbCount - wbStart, 0);
    bus.dbg_addr = 2'd1;
    #1 checkOutput("rst.reg1", bus.dbg_data, 16'h0000);
    checkOutput("rst.alu_A", bus.alu_A, 16'h0000);
    checkOutput("rst.alu_B", bus.alu_B, 16'h0000);
    checkOutput("rst.func", bus.alu_FuncCode, 4'h0);
    checkOutput("rst.wb_data", bus.wb_data, 16'h0000);
    checkOutput("rst.wb_rd", bus.wb_rd, 2'd0);
    checkOutput("rst.ready", bus.cmd_ready, 1'b1);

    // Normal operation resumes after the abort
    issueOne(F_ADD, 2'd1, 2'd0, 2'd0, 1'b1, 16'h0005);
    runWb("post");
    bus.dbg_addr = 2'd1;
    #1 checkOutput("post.reg1", bus.dbg_data, 16'h0005);
    checkOutput("end.sbEmpty", sbQ.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
